// File: rtl/ecc_pkg.sv
// Shared field-arithmetic definitions for the modular multiplier and the inverse block.
// Holds the default field width, the reduction datapath width and the sequencer state encoding.
package ecc_pkg;

    localparam int FIELD_W = 8;
    // A doubled or summed residue of a value < p needs one extra bit before reduction.
    localparam int ACC_W   = FIELD_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mod_dbl_add.sv
// One MSB-first interleaved step: acc_next = (2*acc + mul_bit*a) mod p.
// acc and a are below p, so each conditional subtraction removes at most one p.
module mod_dbl_add
    import ecc_pkg::*;
#(
    parameter int W = FIELD_W
) (
    input  logic [W-1:0] acc,
    input  logic [W-1:0] a,
    input  logic [W-1:0] p,
    input  logic         mul_bit,
    output logic [W-1:0] acc_next
);

    logic [W:0] pw;
    logic [W:0] dbl;
    logic [W:0] t;
    logic [W:0] u;

    assign pw  = {1'b0, p};
    assign dbl = {acc, 1'b0};
    assign t   = (dbl >= pw) ? (dbl - pw) : dbl;
    assign u   = t + {1'b0, a};

    // t is already reduced below p, so its top bit is always clear after reduction.
    assign acc_next = mul_bit ? W'((u >= pw) ? (u - pw) : u) : W'(t);

endmodule

// File: rtl/mod_mul.sv
// Sequential modular multiplier: result = (a*b) mod p, one multiplier bit per clock, MSB first.
// Constant time: always W steps in RUN regardless of operand values.
module mod_mul
    import ecc_pkg::*;
#(
    parameter int W = FIELD_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] p,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [W-1:0] result
);

    localparam int IW = (W > 1) ? $clog2(W) : 1;

    // Handshake: start is only sampled while idle (busy low); a/b/p are captured on that
    // edge. done pulses for exactly one cycle with result/err valid; both hold afterwards.
    state_t         state;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [W-1:0]   p_q;
    logic [W-1:0]   acc;
    logic [IW-1:0]  idx;
    logic           err_q;
    logic [W-1:0]   acc_next;
    logic           bad_op;

    assign bad_op = (a >= p) || (b >= p) || (p < W'(3)) || !p[0];

    mod_dbl_add #(.W(W)) u_step (
        .acc      (acc),
        .a        (a_q),
        .p        (p_q),
        .mul_bit  (b_q[idx]),
        .acc_next (acc_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            result <= '0;
            a_q    <= '0;
            b_q    <= '0;
            p_q    <= '0;
            acc    <= '0;
            idx    <= '0;
            err_q  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        p_q   <= p;
                        acc   <= '0;
                        idx   <= IW'(W - 1);
                        err_q <= bad_op;
                        busy  <= 1'b1;
                        state <= bad_op ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc <= acc_next;
                    idx <= idx - 1'b1;
                    if (idx == '0) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    result <= err_q ? '0 : acc;
                    err    <= err_q;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mod_mul.sv
// Directed bench for mod_mul: reset, products, inverse pairs, range errors,
// start-while-busy, mid-run reset and back-to-back operation.
module tb_mod_mul;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] p;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] result;

    int errors = 0;
    int checks = 0;

    mod_mul #(.W(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .p      (p),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one operation from 1 time unit after an edge; returns latency in edges
    // after acceptance (0 if done never came) and the values seen with done.
    task automatic run_op(input logic [7:0] xa, input logic [7:0] xb, input logic [7:0] xp,
                          output int lat, output logic [7:0] res, output logic e);
        a = xa;
        b = xb;
        p = xp;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 0;
        res = 8'hxx;
        e = 1'bx;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = n;
                res = result;
                e = err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        a = 8'd0;
        b = 8'd0;
        p = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, err, result} !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b err=%b result=%0d, want all 0",
                     busy, done, err, result);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_product(input string name, input logic [7:0] xa, input logic [7:0] xb,
                                input logic [7:0] xp, input logic [7:0] want);
        int lat;
        logic [7:0] res;
        logic e;
        run_op(xa, xb, xp, lat, res, e);
        checks++;
        if (lat !== 9) begin
            errors++;
            $display("FAIL %s_latency: got %0d, want 9", name, lat);
        end
        checks++;
        if (res !== want || e !== 1'b0) begin
            errors++;
            $display("FAIL %s_result: got result=%0d err=%b, want result=%0d err=0",
                     name, res, e, want);
        end
    endtask

    task automatic test_basic();
        test_product("mul_5x9_p23", 8'd5, 8'd9, 8'd23, 8'd22);
        // done is a single-cycle pulse; result holds afterwards
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || result !== 8'd22 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse_hold: got done=%b result=%0d busy=%b, want 0/22/0",
                     done, result, busy);
        end
    endtask

    task automatic test_inverse();
        test_product("inv_3x8_p23", 8'd3, 8'd8, 8'd23, 8'd1);
        test_product("inv_22x22_p23", 8'd22, 8'd22, 8'd23, 8'd1);
    endtask

    task automatic test_max_width();
        test_product("max_250x250_p251", 8'd250, 8'd250, 8'd251, 8'd1);
        test_product("zero_0x250_p251", 8'd0, 8'd250, 8'd251, 8'd0);
        test_product("mul_200x100_p251", 8'd200, 8'd100, 8'd251, 8'd171);
    endtask

    task automatic test_err();
        int lat;
        logic [7:0] res;
        logic e;
        run_op(8'd23, 8'd4, 8'd23, lat, res, e);
        checks++;
        if (lat !== 1 || e !== 1'b1 || res !== 8'd0) begin
            errors++;
            $display("FAIL err_a_ge_p: got lat=%0d err=%b result=%0d, want 1/1/0", lat, e, res);
        end
        run_op(8'd3, 8'd5, 8'd22, lat, res, e);
        checks++;
        if (lat !== 1 || e !== 1'b1 || res !== 8'd0) begin
            errors++;
            $display("FAIL err_even_p: got lat=%0d err=%b result=%0d, want 1/1/0", lat, e, res);
        end
        run_op(8'd0, 8'd0, 8'd1, lat, res, e);
        checks++;
        if (lat !== 1 || e !== 1'b1 || res !== 8'd0) begin
            errors++;
            $display("FAIL err_small_p: got lat=%0d err=%b result=%0d, want 1/1/0", lat, e, res);
        end
        run_op(8'd2, 8'd30, 8'd23, lat, res, e);
        checks++;
        if (lat !== 1 || e !== 1'b1) begin
            errors++;
            $display("FAIL err_b_ge_p: got lat=%0d err=%b, want 1/1", lat, e);
        end
        test_product("err_clear_3x8_p23", 8'd3, 8'd8, 8'd23, 8'd1);
    endtask

    task automatic test_busy_start();
        int lat;
        a = 8'd5;
        b = 8'd9;
        p = 8'd23;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL busy_in_run: got busy=%b done=%b, want 1/0", busy, done);
        end
        @(posedge clk);
        #1;
        a = 8'd7;
        b = 8'd2;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 0;
        for (int n = 3; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = n;
                break;
            end
        end
        checks++;
        if (lat !== 9 || result !== 8'd22 || err !== 1'b0) begin
            errors++;
            $display("FAIL start_while_busy: got lat=%0d result=%0d err=%b, want 9/22/0",
                     lat, result, err);
        end
    endtask

    task automatic test_reset_mid_run();
        int seen_done;
        a = 8'd5;
        b = 8'd9;
        p = 8'd23;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || result !== 8'd0 || done !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_run: got busy=%b result=%0d done=%b err=%b, want 0/0/0/0",
                     busy, result, done, err);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        seen_done = 0;
        for (int n = 0; n < 12; n++) begin
            @(posedge clk);
            #1;
            if (done || busy) seen_done++;
        end
        checks++;
        if (seen_done !== 0) begin
            errors++;
            $display("FAIL no_done_after_reset: got %0d active cycles, want 0", seen_done);
        end
        test_product("after_reset_3x8_p23", 8'd3, 8'd8, 8'd23, 8'd1);
    endtask

    task automatic test_back_to_back();
        // each run_op starts in the done cycle of the previous one
        test_product("b2b_first_5x9", 8'd5, 8'd9, 8'd23, 8'd22);
        test_product("b2b_second_22x22", 8'd22, 8'd22, 8'd23, 8'd1);
        test_product("b2b_third_200x100", 8'd200, 8'd100, 8'd251, 8'd171);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_inverse();
        test_max_width();
        test_err();
        test_busy_start();
        test_reset_mid_run();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
